// File: rtl/exe_unit_seq.sv
// Sequential execution unit behind a valid/ready handshake: ALU ops finish on the
// accept edge, while CRC and MUL iterate one operand bit per cycle for M cycles.
module exe_unit_seq #(
  parameter int M     = 9,
  parameter int N     = 4,
  parameter int WPOLY = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  input  logic [N-1:0] i_oper,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic         o_SF,
  output logic         o_OF,
  output logic         o_NF,
  output logic         o_BF,
  output logic         o_ZF,
  output logic         o_err
);
  localparam int W  = WPOLY - 1;
  localparam int CW = $clog2(M);
  localparam int ZW = $clog2(2 * M) + 1;

  localparam logic [N-1:0] OP_SUB    = N'(0);
  localparam logic [N-1:0] OP_XOR    = N'(1);
  localparam logic [N-1:0] OP_NAND   = N'(2);
  localparam logic [N-1:0] OP_SHL    = N'(3);
  localparam logic [N-1:0] OP_SHR    = N'(4);
  localparam logic [N-1:0] OP_CRCGEN = N'(5);
  localparam logic [N-1:0] OP_CRCCHK = N'(6);
  localparam logic [N-1:0] OP_ZCNT   = N'(7);
  localparam logic [N-1:0] OP_MUL    = N'(8);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_reg, state_next;

  logic [M-1:0]    a_reg, b_reg;
  logic [N-1:0]    op_reg;
  logic [CW-1:0]   cnt_reg, a_idx;
  logic [W-1:0]    crc_reg, crc_next;
  logic [2*M-1:0]  acc_reg, acc_next;
  logic [M-1:0]    result_reg, res_next, diff;
  logic            of_reg, of_next, err_reg, err_next;
  logic            sf_reg, nf_reg, bf_reg, zf_reg;
  logic            crc_fb, last_bit, is_crc_in, serial_in, load_out;
  logic [ZW-1:0]   zcnt;

  assign is_crc_in = (i_oper == OP_CRCGEN) || (i_oper == OP_CRCCHK);
  assign serial_in = (is_crc_in && i_argB[WPOLY-1]) || (i_oper == OP_MUL);
  assign last_bit  = (cnt_reg == CW'(M - 1));
  assign load_out  = ((state_reg == IDLE) && i_valid && !serial_in) ||
                     ((state_reg == BUSY) && last_bit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid) state_next = serial_in ? BUSY : DONE;
      BUSY:    if (last_bit) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_reg == IDLE);
    o_valid = (state_reg == DONE);
  end

  // One serial step: CRC consumes A MSB-first, MUL consumes B LSB-first.
  always_comb begin
    a_idx    = CW'(M - 1) - cnt_reg;
    crc_fb   = crc_reg[W-1] ^ a_reg[a_idx];
    crc_next = (crc_reg << 1) ^ (crc_fb ? b_reg[W-1:0] : '0);
    acc_next = acc_reg + (b_reg[cnt_reg] ? ({{M{1'b0}}, a_reg} << cnt_reg) : '0);
  end

  always_comb begin
    zcnt = '0;
    for (int k = 0; k < M; k++) begin
      zcnt = zcnt + {{(ZW-1){1'b0}}, ~i_argA[k]} + {{(ZW-1){1'b0}}, ~i_argB[k]};
    end
  end

  always_comb begin
    res_next = '0;
    of_next  = 1'b0;
    err_next = 1'b0;
    diff     = i_argA - i_argB;
    if (state_reg == BUSY) begin
      case (op_reg)
        OP_CRCGEN: res_next = M'(crc_next);
        OP_CRCCHK: res_next = M'(crc_next ^ b_reg[M-1 -: W]);
        default: begin
          res_next = acc_next[M-1:0];
          of_next  = |acc_next[2*M-1:M];
        end
      endcase
    end else begin
      case (i_oper)
        OP_SUB: begin
          res_next = diff;
          of_next  = (i_argA[M-1] != i_argB[M-1]) && (diff[M-1] != i_argA[M-1]);
        end
        OP_XOR:  res_next = i_argA ^ i_argB;
        OP_NAND: res_next = ~(i_argA & i_argB);
        OP_SHL:  res_next = (i_argB >= M'(M)) ? '0 : (i_argA << i_argB);
        OP_SHR:  res_next = (i_argB >= M'(M)) ? '0 : (i_argA >> i_argB);
        // Only reached here with a polynomial lacking its leading term.
        OP_CRCGEN, OP_CRCCHK: err_next = ~i_argB[WPOLY-1];
        OP_ZCNT: res_next = M'(zcnt);
        OP_MUL:  res_next = '0;
        default: err_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      cnt_reg    <= '0;
      crc_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      of_reg     <= 1'b0;
      err_reg    <= 1'b0;
      sf_reg     <= 1'b0;
      nf_reg     <= 1'b0;
      bf_reg     <= 1'b0;
      zf_reg     <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && i_valid) begin
        a_reg   <= i_argA;
        b_reg   <= i_argB;
        op_reg  <= i_oper;
        cnt_reg <= '0;
        crc_reg <= '0;
        acc_reg <= '0;
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
        crc_reg <= crc_next;
        acc_reg <= acc_next;
      end
      if (load_out) begin
        result_reg <= res_next;
        of_reg     <= of_next;
        err_reg    <= err_next;
        sf_reg     <= res_next[M-1];
        nf_reg     <= ~^res_next;
        bf_reg     <= (res_next != '0) && ((res_next & (res_next - 1'b1)) == '0);
        zf_reg     <= (res_next == '0);
      end
    end
  end

  assign o_result = result_reg;
  assign o_OF     = of_reg;
  assign o_err    = err_reg;
  assign o_SF     = sf_reg;
  assign o_NF     = nf_reg;
  assign o_BF     = bf_reg;
  assign o_ZF     = zf_reg;

endmodule

// File: tb/tb_exe_unit_seq.sv
// Bench for exe_unit_seq: directed vector table, backpressure and mid-op reset
// sequences, then random operations against an arithmetic reference model.
module tb_exe_unit_seq;
  localparam int M     = 9;
  localparam int N     = 4;
  localparam int WPOLY = 4;
  localparam int W     = WPOLY - 1;

  logic         i_clk, i_rst_n, i_valid, i_ready;
  logic [M-1:0] i_argA, i_argB;
  logic [N-1:0] i_oper;
  logic         o_ready, o_valid, o_SF, o_OF, o_NF, o_BF, o_ZF, o_err;
  logic [M-1:0] o_result;

  int n_vec = 0;
  int n_bad = 0;

  exe_unit_seq #(.M(M), .N(N), .WPOLY(WPOLY)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_argA(i_argA), .i_argB(i_argB), .i_oper(i_oper), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_SF(o_SF), .o_OF(o_OF),
    .o_NF(o_NF), .o_BF(o_BF), .o_ZF(o_ZF), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] op;
    logic [M-1:0] res;
    logic         of_f;
    logic         err;
    logic         sf;
    logic         nf;
    logic         bf;
    logic         zf;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: CRC by polynomial long division, SUB overflow by signed range,
  // MUL by full-width product.
  function automatic vec_t model(input logic [M-1:0] a, input logic [M-1:0] b,
                                 input logic [N-1:0] op);
    vec_t v;
    logic [M+W-1:0] dvd;
    logic [2*M-1:0] pa, pb, prod;
    int sa, sb, d, ones;
    v.a = a; v.b = b; v.op = op;
    v.res = '0; v.of_f = 1'b0; v.err = 1'b0; v.lat = 1;
    case (int'(op))
      0: begin
        v.res = a - b;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d  = sa - sb;
        v.of_f = (d > (2 ** (M - 1)) - 1) || (d < -(2 ** (M - 1)));
      end
      1: v.res = a ^ b;
      2: v.res = ~(a & b);
      3: v.res = (int'(b) < M) ? (a << b) : '0;
      4: v.res = (int'(b) < M) ? (a >> b) : '0;
      5, 6: begin
        if (!b[WPOLY-1]) v.err = 1'b1;
        else begin
          dvd = {a, {W{1'b0}}};
          for (int i = M + W - 1; i >= W; i--)
            if (dvd[i]) dvd[i -: WPOLY] = dvd[i -: WPOLY] ^ {1'b1, b[W-1:0]};
          v.res = M'(dvd[W-1:0]);
          if (int'(op) == 6) v.res = v.res ^ M'(b[M-1 -: W]);
          v.lat = M + 1;
        end
      end
      7: v.res = M'(2 * M - $countones(a) - $countones(b));
      8: begin
        pa = {{M{1'b0}}, a};
        pb = {{M{1'b0}}, b};
        prod = pa * pb;
        v.res = prod[M-1:0];
        v.of_f = (prod >> M) != 0;
        v.lat = M + 1;
      end
      default: v.err = 1'b1;
    endcase
    ones = $countones(v.res);
    v.sf = v.res[M-1];
    v.nf = (ones % 2 == 0);
    v.bf = (ones == 1);
    v.zf = (v.res == '0);
    return v;
  endfunction

  task automatic check_outputs(input vec_t e, input string tag);
    check({tag, " result"}, 32'(o_result), 32'(e.res));
    check({tag, " OF"},  32'(o_OF),  32'(e.of_f));
    check({tag, " err"}, 32'(o_err), 32'(e.err));
    check({tag, " SF"},  32'(o_SF),  32'(e.sf));
    check({tag, " NF"},  32'(o_NF),  32'(e.nf));
    check({tag, " BF"},  32'(o_BF),  32'(e.bf));
    check({tag, " ZF"},  32'(o_ZF),  32'(e.zf));
  endtask

  // Present a request and return #1 after its accept edge; operands are then scrambled.
  task automatic send(input vec_t e);
    int w = 0;
    while (!o_ready && w < 4 * M) begin
      @(posedge i_clk); #1; w++;
    end
    check("ready before send", 32'(o_ready), 32'd1);
    i_argA = e.a; i_argB = e.b; i_oper = e.op; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_argA = M'($urandom); i_argB = M'($urandom); i_oper = N'($urandom);
  endtask

  // Wait for o_valid, check latency/result, hold backpressure, then hand the result off.
  task automatic collect(input vec_t e, input int hold, input string tag);
    int w = 0;
    while (!o_valid && w < 3 * M) begin
      @(posedge i_clk); #1; w++;
    end
    check({tag, " latency"}, 32'(w + 1), 32'(e.lat));
    check_outputs(e, tag);
    $display("op=%0d a=%03h b=%03h -> res=%03h OF=%0b err=%0b SF=%0b NF=%0b BF=%0b ZF=%0b lat=%0d [%s]",
             e.op, e.a, e.b, o_result, o_OF, o_err, o_SF, o_NF, o_BF, o_ZF, w + 1, tag);
    for (int k = 0; k < hold; k++) begin
      @(posedge i_clk); #1;
      check({tag, " hold o_valid"}, 32'(o_valid), 32'd1);
      check({tag, " hold o_ready"}, 32'(o_ready), 32'd0);
      check({tag, " hold result"}, 32'(o_result), 32'(e.res));
      check({tag, " hold flags"}, {26'd0, o_SF, o_OF, o_NF, o_BF, o_ZF, o_err},
            {26'd0, e.sf, e.of_f, e.nf, e.bf, e.zf, e.err});
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check({tag, " o_valid drop"}, 32'(o_valid), 32'd0);
    check({tag, " o_ready back"}, 32'(o_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t e, input int hold, input string tag);
    send(e);
    collect(e, hold, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e, e2;
    logic [M-1:0] ra, rb;
    logic [N-1:0] rop;

    vecs[0]  = '{9'h100, 9'h001, 4'd0,  9'h0FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{9'h001, 9'h00B, 4'd5,  9'h003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10};
    vecs[2]  = '{9'h001, 9'h0CB, 4'd6,  9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10};
    vecs[3]  = '{9'd20,  9'd30,  4'd8,  9'd88,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[4]  = '{9'd3,   9'd5,   4'd8,  9'd15,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10};
    vecs[5]  = '{9'h001, 9'd9,   4'd3,  9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[6]  = '{9'h100, 9'd8,   4'd4,  9'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{9'h0AA, 9'h055, 4'd12, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[8]  = '{9'h155, 9'h0F0, 4'd1,  9'h1A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{9'h1FF, 9'h1FF, 4'd2,  9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{9'h1FF, 9'h000, 4'd7,  9'h009, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[11] = '{9'h0F0, 9'h003, 4'd5,  9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[12] = '{9'h0FF, 9'h1FF, 4'd0,  9'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_argA = '0; i_argB = '0; i_oper = '0;
    #1;
    check("reset o_ready", 32'(o_ready), 32'd1);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset result", 32'(o_result), 32'd0);
    check("reset flags", {26'd0, o_SF, o_OF, o_NF, o_BF, o_ZF, o_err}, 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 13; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Backpressure: a second request is held pending while the first sits in DONE.
    e  = vecs[0];
    e2 = '{9'h0F0, 9'h00F, 4'd1, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    send(e);
    i_argA = e2.a; i_argB = e2.b; i_oper = e2.op; i_valid = 1'b1;
    collect(e, 5, "bp_first");
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    collect(e2, 0, "bp_second");

    // Reset during the 4th BUSY cycle of a CRC aborts it and clears everything.
    run_op(vecs[12], 0, "pre_reset");
    e = model(9'h1AB, 9'h00B, 4'd5);
    send(e);
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("abort o_valid", 32'(o_valid), 32'd0);
    check("abort o_ready", 32'(o_ready), 32'd1);
    check("abort result", 32'(o_result), 32'd0);
    check("abort flags", {26'd0, o_SF, o_OF, o_NF, o_BF, o_ZF, o_err}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("abort no result", 32'(o_valid), 32'd0);
    run_op(e, 0, "post_reset");

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 4) == 0) ? N'($urandom_range(9, 15)) : N'($urandom_range(0, 8));
      ra  = M'($urandom);
      rb  = M'($urandom);
      if (rop == 4'd3 || rop == 4'd4) rb = M'($urandom_range(0, 12));
      if ((rop == 4'd5 || rop == 4'd6) && $urandom_range(0, 3) != 0) rb[WPOLY-1] = 1'b1;
      e = model(ra, rb, rop);
      run_op(e, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/exe_unit_seq.md
Name: exe_unit_seq

Overview:
Sequential, parametrised successor of the combinational execution unit. It accepts one operation at a time over a valid/ready handshake and registers its operands. Single-cycle ops complete in one cycle; CRC and multiply use bit-serial datapaths that run for M cycles. It sits between the SPI command decoder and the SPI response shifter and returns a registered result plus flags, held until the consumer accepts it.

Parameters:
M, 9, operand/result width (M >= 4)
N, 4, opcode width
WPOLY, 4, CRC polynomial width including leading term; CRC width W = WPOLY-1 (WPOLY <= M)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  operation request
o_ready  out  1  unit can accept a request
i_argA  in  M  operand A
i_argB  in  M  operand B; for CRC ops, [WPOLY-1:0] is the polynomial and [M-1:M-W] is the received CRC
i_oper  in  N  opcode
o_valid  out  1  result/flags valid
i_ready  in  1  consumer accepts result
o_result  out  M  result
o_SF  out  1  sign flag = o_result[M-1]
o_OF  out  1  overflow flag (op-specific)
o_NF  out  1  1 when o_result has an even number of ones
o_BF  out  1  1 when o_result has exactly one bit set
o_ZF  out  1  1 when o_result == 0
o_err  out  1  illegal opcode or invalid polynomial

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; o_ready=1; o_valid=0; o_result=0; all flags=0; o_err=0; internal counters and operand registers = 0. Reset asserted mid-operation aborts the op immediately; no result is produced.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: o_ready=1. When i_valid=1, capture i_argA, i_argB, i_oper.
    - Single-cycle or error op -> DONE.
    - CRC or MUL op -> BUSY, with cnt=0.
  - BUSY: o_ready=0. Advance one bit per cycle; cnt++. When cnt==M-1 at the clock edge -> DONE.
  - DONE: o_ready=0; o_valid=1; outputs stable. When i_ready=1 -> IDLE, and o_valid drops the next cycle.
- Operand changes after capture are ignored. No new request is accepted while in DONE.
- Latency from the accept edge to o_valid high: single-cycle ops 1 cycle; CRC/MUL M+1 cycles. Sustained throughput is one op per 2 cycles (single-cycle) or M+2 cycles (serial).
- Opcodes:
  - 0 SUB: A-B mod 2^M. OF = signed overflow (A[M-1]!=B[M-1] && R[M-1]!=A[M-1]).
  - 1 XOR. 2 NAND. OF=0.
  - 3 SHL, 4 SHR (logical) by unsigned B. If B >= M, result = 0. OF=0.
  - 5 CRCGEN: W-bit remainder of A·x^W mod P, placed in o_result[W-1:0], upper bits 0.
    - P = {1, B[W-1:0]}; requires B[WPOLY-1]=1.
    - Serial LFSR r (W bits, init 0), A bits MSB first, one per cycle: fb = r[W-1]^bit; r = {r[W-2:0],0} ^ (fb ? B[W-1:0] : 0).
  - 6 CRCCHK: same LFSR, then result[W-1:0] = r ^ B[M-1:M-W]. A zero result means the CRC matches. OF=0.
  - 7 ZCNT: number of zero bits in {A,B}, in o_result[$clog2(2M):0]. OF=0.
  - 8 MUL: unsigned shift-add, one multiplier bit of B per cycle (LSB first), 2M-bit accumulator. Result = low M bits; OF=1 if the high M bits are nonzero.
  - 9..2^N-1: illegal. Result=0, o_err=1, 1-cycle latency.
- For ops 5/6, B[WPOLY-1]=0 sets o_err=1 and result=0 with 1-cycle latency; no BUSY phase.
- Flags SF, NF, BF, ZF are computed from the final registered o_result. All flags and o_err are registered together with o_result and update only on entry to DONE.
- Simultaneous events:
  - i_valid in DONE is ignored (o_ready=0); the requester must hold i_valid.
  - i_ready outside DONE has no effect.

Test Plan:
- Reset then SUB, A=9'h100, B=9'h001, i_ready=1 -> o_valid 1 cycle after accept; o_result=9'h0FF, OF=1, SF=0, NF=1, ZF=0, BF=0.
- CRCGEN, M=9, WPOLY=4, A=9'h001, B=9'h00B -> o_valid at accept+10 cycles; o_result=9'h003. Then CRCCHK, A=9'h001, B={3'b011,2'b00,4'hB} -> o_result=0, ZF=1.
- MUL, A=20, B=30 -> o_result=88 (600 mod 512), OF=1, latency M+1. MUL, A=3, B=5 -> 15, OF=0, NF=1.
- SHL, A=9'h001, B=9 -> o_result=0, ZF=1. SHR, A=9'h100, B=8 -> o_result=9'h001, BF=1. Opcode 12 -> o_err=1, o_result=0.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_result and flags stable; o_ready=0; a new i_valid is not accepted until the cycle after i_ready=1.
- Reset asserted on the 4th BUSY cycle of a CRC -> all outputs 0 immediately, o_ready=1; the next op runs correctly.
